ram_wr_arb: RTL and testbench



---
 rtl/ram_ctrl_pkg.sv | 11 +
 rtl/ram_wr_arb_rr_pick2.sv | 29 ++
 rtl/ram_wr_arb.sv | 94 +++++++++
 tb/tb_ram_wr_arb.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared RAM controller constants: geometry and arbiter FSM encoding.
// Imported by the write arbiter and the planned read-side arbiter.
package ram_ctrl_pkg;

  localparam int RAM_ADDR_W = 5;
  localparam int RAM_DATA_W = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

endpackage

// File: rtl/ram_wr_arb_rr_pick2.sv
// Two-way winner select; win=1 means requester 1.
// RAM_WR_ARB_FIXED_PRIO_EN: ties go to requester 0, last ignored.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic win
);

`ifdef RAM_WR_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    win = 1'b0;
    if (req1 && !req0) win = 1'b1;
  end
`else
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (req0 && req1):  win = ~last;
      (req1 && !req0): win = 1'b1;
      default:         win = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/ram_wr_arb.sv
// Burst write-port arbiter for the shared dual-port RAM.
// RAM_WR_ARB_FIXED_PRIO_EN: requester 0 always wins ties.
module ram_wr_arb
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = RAM_ADDR_W,
  parameter int DATA_W    = RAM_DATA_W,
  parameter int BURST_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] base0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] base1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              busy
);

  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  logic [0:0]        state;
  logic              sel;
  logic              last;
  logic              win;
  logic [BW-1:0]     beat;
  logic [ADDR_W-1:0] addr;

  logic in_burst;
  logic req_sel;
  logic gnt;
  logic done;

  rr_pick2 u_pick (
    .req0 (req0),
    .req1 (req1),
    .last (last),
    .win  (win)
  );

  assign in_burst = (state == ST_BURST);
  assign req_sel  = sel ? req1 : req0;
  assign gnt      = in_burst & req_sel;
  assign done     = gnt & (beat == LAST_BEAT);

  assign gnt0  = gnt & ~sel;
  assign gnt1  = gnt & sel;
  assign done0 = done & ~sel;
  assign done1 = done & sel;

  assign ram_wr_en   = gnt;
  assign ram_wr_addr = addr;
  assign ram_wr_data = in_burst ? (sel ? wdata1 : wdata0) : '0;
  assign busy        = in_burst;

  // A withdrawn burst ends like a completed one and is not retried.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sel   <= 1'b0;
      beat  <= '0;
      addr  <= '0;
      last  <= 1'b1;
    end else if (state == ST_IDLE) begin
      if (req0 | req1) begin
        sel   <= win;
        addr  <= win ? base1 : base0;
        beat  <= '0;
        state <= ST_BURST;
      end
    end else begin
      if (gnt) begin
        addr <= addr + 1'b1;
        beat <= beat + 1'b1;
      end
      if (done | ~req_sel) begin
        state <= ST_IDLE;
`ifndef RAM_WR_ARB_FIXED_PRIO_EN
        last  <= sel;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ram_wr_arb.sv
// Directed bench for ram_wr_arb (BURST_LEN=8, ADDR_W=5, DATA_W=8).
// Expectations follow RAM_WR_ARB_FIXED_PRIO_EN when it is defined.
module tb_ram_wr_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [4:0] base0 = '0;
  logic [4:0] base1 = '0;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, done0, done1;
  logic       ram_wr_en, busy;
  logic [4:0] ram_wr_addr;
  logic [7:0] ram_wr_data;

  logic       clr = 1'b1;
  logic [7:0] c0 = '0;
  logic [7:0] c1 = '0;
  int         wr_cnt = 0;
  logic [7:0] mem [32];

  int total = 0;
  int bad   = 0;
  int n0, w, k;
  logic [4:0] a;

  ram_wr_arb #(.ADDR_W(5), .DATA_W(8), .BURST_LEN(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0        (req0),
    .base0       (base0),
    .wdata0      (wdata0),
    .gnt0        (gnt0),
    .done0       (done0),
    .req1        (req1),
    .base1       (base1),
    .wdata1      (wdata1),
    .gnt1        (gnt1),
    .done1       (done1),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Show-ahead producers and the RAM write side.
  assign wdata0 = 8'hA0 + c0;
  assign wdata1 = 8'hB0 + c1;

  always @(posedge clk) begin
    if (clr) begin
      c0 <= '0;
      c1 <= '0;
    end else begin
      if (gnt0) c0 <= c0 + 8'd1;
      if (gnt1) c1 <= c1 + 8'd1;
    end
    if (ram_wr_en) begin
      mem[ram_wr_addr] <= ram_wr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_en"}, ram_wr_en, 0);
    chk({tag, "_gnt0"}, gnt0, 0);
    chk({tag, "_gnt1"}, gnt1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a request pending: everything stays 0.
    req0 = 1'b1;
    base0 = 5'h04;
    cyc();
    cyc();
    chk_idle("rst");
    chk("rst_done0", done0, 0);
    chk("rst_done1", done1, 0);
    chk("rst_addr", ram_wr_addr, 0);
    chk("rst_data", ram_wr_data, 0);
    rst = 1'b0;
    clr = 1'b0;

    // Single burst from requester 0; base change mid-burst ignored.
    cyc();
    for (int b = 0; b < 8; b++) begin
      chk("t1_gnt0", gnt0, 1);
      chk("t1_gnt1", gnt1, 0);
      chk("t1_en", ram_wr_en, 1);
      chk("t1_addr", ram_wr_addr, 5'h04 + b);
      chk("t1_data", ram_wr_data, 8'hA0 + b);
      chk("t1_done0", done0, (b == 7));
      chk("t1_busy", busy, 1);
      if (b == 2) base0 = 5'h1F;
      cyc();
    end
    chk_idle("t1_end");
    req0 = 1'b0;
    req1 = 1'b1;
    base1 = 5'h1C;
    for (int i = 0; i < 8; i++) begin
      a = 5'h04 + 5'(i);
      chk("t1_mem", mem[a], 8'hA0 + i);
    end

    // Requester 1 burst wrapping past 0x1F.
    cyc();
    for (int b = 0; b < 8; b++) begin
      a = 5'h1C + 5'(b);
      chk("t2_gnt1", gnt1, 1);
      chk("t2_gnt0", gnt0, 0);
      chk("t2_addr", ram_wr_addr, a);
      chk("t2_data", ram_wr_data, 8'hB0 + b);
      chk("t2_done1", done1, (b == 7));
      cyc();
    end
    chk_idle("t2_end");
    req1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a = 5'h1C + 5'(i);
      chk("t2_mem", mem[a], 8'hB0 + i);
    end

    // Both requesting from reset.
    rst = 1'b1;
    clr = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    base0 = 5'h04;
    base1 = 5'h10;
    cyc();
    chk_idle("t3_rst");
    rst = 1'b0;
    clr = 1'b0;
    cyc();
    for (int n = 0; n < 4; n++) begin
`ifdef RAM_WR_ARB_FIXED_PRIO_EN
      w = 0;
      k = n;
`else
      w = n % 2;
      k = n / 2;
`endif
      for (int b = 0; b < 8; b++) begin
        chk("t3_gnt0", gnt0, (w == 0));
        chk("t3_gnt1", gnt1, (w == 1));
        chk("t3_both", gnt0 & gnt1, 0);
        chk("t3_en", ram_wr_en, 1);
        chk("t3_addr", ram_wr_addr, (w == 1 ? 5'h10 : 5'h04) + b);
        chk("t3_data", ram_wr_data,
            (w == 1 ? 8'hB0 : 8'hA0) + 8 * k + b);
        chk("t3_done0", done0, (w == 0 && b == 7));
        chk("t3_done1", done1, (w == 1 && b == 7));
        cyc();
      end
      chk_idle("t3_gap");
      if (n == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      cyc();
    end
    chk_idle("t3_end");

    // Withdraw after 3 beats; pending requester 1 follows.
    req0 = 1'b1;
    req1 = 1'b1;
    base0 = 5'h08;
    base1 = 5'h14;
    n0 = wr_cnt;
    cyc();
    for (int b = 0; b < 3; b++) begin
      chk("t4_gnt0", gnt0, 1);
      chk("t4_gnt1", gnt1, 0);
      chk("t4_addr", ram_wr_addr, 5'h08 + b);
      cyc();
    end
    req0 = 1'b0;
    #1;
    chk("t4_wd_gnt0", gnt0, 0);
    chk("t4_wd_en", ram_wr_en, 0);
    chk("t4_wd_done0", done0, 0);
    chk("t4_wd_busy", busy, 1);
    chk("t4_wd_gnt1", gnt1, 0);
    cyc();
    chk_idle("t4_gap");
    chk("t4_writes", wr_cnt, n0 + 3);
    cyc();

    // Requester 1 burst, reset asserted on beat 5.
    n0 = wr_cnt;
    for (int b = 0; b < 6; b++) begin
      chk("t5_gnt1", gnt1, 1);
      chk("t5_addr", ram_wr_addr, 5'h14 + b);
      chk("t5_done1", done1, 0);
      if (b == 5) rst = 1'b1;
      cyc();
    end
    chk_idle("t5_rst");
    chk("t5_done1r", done1, 0);
    chk("t5_addr0", ram_wr_addr, 0);
    chk("t5_data0", ram_wr_data, 0);
    chk("t5_writes", wr_cnt, n0 + 6);
    req0 = 1'b1;
    cyc();
    chk_idle("t5_hold");
    chk("t5_writes2", wr_cnt, n0 + 6);
    rst = 1'b0;
    cyc();
    chk("t5_first_gnt0", gnt0, 1);
    chk("t5_first_gnt1", gnt1, 0);
    chk("t5_first_addr", ram_wr_addr, 5'h08);
    req0 = 1'b0;
    req1 = 1'b0;
    cyc();
    cyc();
    chk_idle("t5_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
